// File: rtl/decode_stage.sv
// MIPS D stage: register file with W-stage writeback and write-through,
// D-stage forwarding, immediate extension, branch/jump resolution toward
// fetch, and the D/E pipeline register.
module decode_stage #(
  parameter logic [31:0] PC_BASE = 32'h0000_3000,
  parameter int          FWD_W   = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      IRD,
  input  logic [31:0]      PC4D,
  input  logic             StallD,
  input  logic [FWD_W-1:0] FwdRsD,
  input  logic [FWD_W-1:0] FwdRtD,
  input  logic [31:0]      DataE,
  input  logic [31:0]      DataM,
  input  logic             RegWriteW,
  input  logic [4:0]       WAW,
  input  logic [31:0]      WDW,
  output logic [31:0]      NPC,
  output logic [2:0]       PCsrc,
  output logic             Branch,
  output logic [31:0]      RS_D_OUT,
  output logic [31:0]      RT_D_OUT,
  output logic [31:0]      IRE,
  output logic [31:0]      PC4E,
  output logic [31:0]      RSE,
  output logic [31:0]      RTE,
  output logic [31:0]      EXTE
);

  // A bubble/reset carries PC 0, deliberately not derived from the base PC.
  localparam logic [31:0] PC4E_RST = PC_BASE ^ PC_BASE;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc4;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ext;
  } de_t;

  logic [5:0]  op, funct;
  logic [4:0]  rs_a, rt_a;
  logic [15:0] imm;

  assign op    = IRD[31:26];
  assign rs_a  = IRD[25:21];
  assign rt_a  = IRD[20:16];
  assign imm   = IRD[15:0];
  assign funct = IRD[5:0];

  logic [31:0] grf [32];
  logic [31:0] rs_grf, rt_grf, ext;
  logic        is_br, is_regimm_br, is_j, is_jr;
  de_t         de_q;

  // Register file: sync clear on reset, $0 never written.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) grf[i] <= '0;
    end else if (RegWriteW && WAW != 5'd0) begin
      grf[WAW] <= WDW;
    end
  end

  // GRF read ports with same-cycle write-through from W.
  always_comb begin
    rs_grf = grf[rs_a];
    rt_grf = grf[rt_a];
    if (rs_a == 5'd0)                        rs_grf = '0;
    else if (RegWriteW && WAW == rs_a)       rs_grf = WDW;
    if (rt_a == 5'd0)                        rt_grf = '0;
    else if (RegWriteW && WAW == rt_a)       rt_grf = WDW;
  end

  // Forwarding muxes: 1 = E, 2 = M, anything else = register file.
  always_comb begin
    case (FwdRsD)
      FWD_W'(1): RS_D_OUT = DataE;
      FWD_W'(2): RS_D_OUT = DataM;
      default:   RS_D_OUT = rs_grf;
    endcase
    case (FwdRtD)
      FWD_W'(1): RT_D_OUT = DataE;
      FWD_W'(2): RT_D_OUT = DataM;
      default:   RT_D_OUT = rt_grf;
    endcase
  end

  // Immediate extender: logical ops zero-extend, lui shifts up, rest sign-extend.
  always_comb begin
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: ext = {16'h0, imm};
      OP_LUI:                   ext = {imm, 16'h0};
      default:                  ext = {{16{imm[15]}}, imm};
    endcase
  end

  // Control-flow class of the instruction in D.
  always_comb begin
    is_regimm_br = (op == OP_REGIMM) && (rt_a == 5'd0 || rt_a == 5'd1);
    is_br = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
            (op == OP_BGTZ) || is_regimm_br;
    is_j  = (op == OP_J) || (op == OP_JAL);
    is_jr = (op == OP_SPECIAL) && (funct == FN_JR || funct == FN_JALR);
  end

  // Next-PC source and target back to fetch.
  always_comb begin
    PCsrc = 3'd0;
    NPC   = '0;
    if (is_br) begin
      PCsrc = 3'd1;
      NPC   = PC4D + {{14{imm[15]}}, imm, 2'b00};
    end else if (is_j) begin
      PCsrc = 3'd2;
      NPC   = {PC4D[31:28], IRD[25:0], 2'b00};
    end else if (is_jr) begin
      PCsrc = 3'd3;
    end
  end

  // Branch condition on forwarded operands, signed compares.
  always_comb begin
    Branch = 1'b0;
    case (op)
      OP_BEQ:    Branch = (RS_D_OUT == RT_D_OUT);
      OP_BNE:    Branch = (RS_D_OUT != RT_D_OUT);
      OP_BLEZ:   Branch = ($signed(RS_D_OUT) <= 0);
      OP_BGTZ:   Branch = ($signed(RS_D_OUT) > 0);
      OP_REGIMM: begin
        if (rt_a == 5'd0)      Branch = ($signed(RS_D_OUT) < 0);
        else if (rt_a == 5'd1) Branch = ($signed(RS_D_OUT) >= 0);
      end
      default:   Branch = 1'b0;
    endcase
  end

  // D/E register: reset or stall inserts a nop bubble; reset wins.
  always_ff @(posedge Clk) begin
    if (Reset || StallD) begin
      de_q <= '{ir: '0, pc4: PC4E_RST, rs: '0, rt: '0, ext: '0};
    end else begin
      de_q <= '{ir: IRD, pc4: PC4D, rs: RS_D_OUT, rt: RT_D_OUT, ext: ext};
    end
  end

  assign IRE  = de_q.ir;
  assign PC4E = de_q.pc4;
  assign RSE  = de_q.rs;
  assign RTE  = de_q.rt;
  assign EXTE = de_q.ext;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reference model of the D stage compared
// every cycle, plus hand-computed literal expectations for key vectors.
module tb_decode_stage;

  logic        Clk, Reset, StallD, RegWriteW;
  logic [31:0] IRD, PC4D, DataE, DataM, WDW;
  logic [1:0]  FwdRsD, FwdRtD;
  logic [4:0]  WAW;
  logic [31:0] NPC, RS_D_OUT, RT_D_OUT, IRE, PC4E, RSE, RTE, EXTE;
  logic [2:0]  PCsrc;
  logic        Branch;

  int errors = 0;
  int checks = 0;

  decode_stage #(.PC_BASE(32'h0000_3000), .FWD_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .IRD(IRD), .PC4D(PC4D), .StallD(StallD),
    .FwdRsD(FwdRsD), .FwdRtD(FwdRtD), .DataE(DataE), .DataM(DataM),
    .RegWriteW(RegWriteW), .WAW(WAW), .WDW(WDW),
    .NPC(NPC), .PCsrc(PCsrc), .Branch(Branch),
    .RS_D_OUT(RS_D_OUT), .RT_D_OUT(RT_D_OUT),
    .IRE(IRE), .PC4E(PC4E), .RSE(RSE), .RTE(RTE), .EXTE(EXTE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] npc, rs, rt, ext;
    logic [2:0]  pcsrc;
    logic        br;
  } dec_t;

  logic [31:0] mrf [32];
  logic [31:0] m_ir, m_pc4, m_rs, m_rt, m_ext;
  bit          chk_en = 0;

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (RegWriteW && WAW == a) return WDW;
    return mrf[a];
  endfunction

  function automatic logic [31:0] mfwd(input logic [1:0] sel, input logic [31:0] g);
    return (sel == 2'd1) ? DataE : (sel == 2'd2) ? DataM : g;
  endfunction

  function automatic dec_t mdec();
    dec_t d;
    int unsigned opc, rt_n, fn;
    longint s_rs, s_rt, simm;
    opc  = IRD >> 26;
    rt_n = (IRD >> 16) & 31;
    fn   = IRD & 63;
    d.rs = mfwd(FwdRsD, mread(IRD[25:21]));
    d.rt = mfwd(FwdRtD, mread(IRD[20:16]));
    s_rs = longint'($signed(d.rs));
    s_rt = longint'($signed(d.rt));
    simm = longint'($signed(IRD[15:0]));
    if (opc >= 12 && opc <= 14)  d.ext = IRD & 32'hFFFF;
    else if (opc == 15)          d.ext = (IRD & 32'hFFFF) * 65536;
    else                         d.ext = 32'(simm);
    d.npc = 0; d.pcsrc = 0; d.br = 0;
    if ((opc >= 4 && opc <= 7) || (opc == 1 && rt_n <= 1)) begin
      d.pcsrc = 1;
      d.npc   = 32'(longint'(PC4D) + simm * 4);
      case (opc)
        4: d.br = (s_rs == s_rt);
        5: d.br = (s_rs != s_rt);
        6: d.br = (s_rs <= 0);
        7: d.br = (s_rs > 0);
        default: d.br = (rt_n == 0) ? (s_rs < 0) : (s_rs >= 0);
      endcase
    end else if (opc == 2 || opc == 3) begin
      d.pcsrc = 2;
      d.npc   = (PC4D & 32'hF000_0000) | ((IRD & 32'h03FF_FFFF) * 4);
    end else if (opc == 0 && (fn == 8 || fn == 9)) begin
      d.pcsrc = 3;
    end
    return d;
  endfunction

  // Model state advance at each active edge.
  initial forever begin
    dec_t d;
    @(posedge Clk);
    d = mdec();
    if (Reset) begin
      for (int i = 0; i < 32; i++) mrf[i] = 0;
      {m_ir, m_pc4, m_rs, m_rt, m_ext} = '0;
      chk_en = 1;
    end else begin
      if (StallD) {m_ir, m_pc4, m_rs, m_rt, m_ext} = '0;
      else begin
        m_ir = IRD; m_pc4 = PC4D; m_rs = d.rs; m_rt = d.rt; m_ext = d.ext;
      end
      if (RegWriteW && WAW != 0) mrf[WAW] = WDW;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  initial forever begin
    dec_t d;
    @(negedge Clk);
    if (chk_en) begin
      d = mdec();
      chk("m_NPC", NPC, d.npc);
      chk("m_PCsrc", 32'(PCsrc), 32'(d.pcsrc));
      chk("m_Branch", 32'(Branch), 32'(d.br));
      chk("m_RS_D_OUT", RS_D_OUT, d.rs);
      chk("m_RT_D_OUT", RT_D_OUT, d.rt);
      chk("m_IRE", IRE, m_ir);
      chk("m_PC4E", PC4E, m_pc4);
      chk("m_RSE", RSE, m_rs);
      chk("m_RTE", RTE, m_rt);
      chk("m_EXTE", EXTE, m_ext);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    RegWriteW = 1'b1; WAW = a; WDW = v;
  endtask

  initial begin
    Reset = 1; StallD = 0; RegWriteW = 0; WAW = 0; WDW = 0;
    IRD = 0; PC4D = 0; DataE = 0; DataM = 0; FwdRsD = 0; FwdRtD = 0;
    tick();
    Reset = 0;
    chk("rst_IRE", IRE, 32'h0);
    chk("rst_PC4E", PC4E, 32'h0);
    chk("rst_EXTE", EXTE, 32'h0);
    @(negedge Clk);
    chk("rst_PCsrc", 32'(PCsrc), 32'd0);
    chk("rst_NPC", NPC, 32'h0);

    // write $5, then read it through ori $6,$5,0
    wr(5, 32'h1234); tick();
    RegWriteW = 0; IRD = 32'h34A6_0000;
    @(negedge Clk); chk("grf_rs5", RS_D_OUT, 32'h1234);
    tick(); chk("grf_RSE5", RSE, 32'h1234);

    // write to $0 is dropped
    wr(0, 32'hFFFF_FFFF); IRD = 32'h3406_0000;
    @(negedge Clk); chk("zero_rs", RS_D_OUT, 32'h0);
    tick(); chk("zero_RSE", RSE, 32'h0);

    // same-cycle write-through, also captured into D/E
    wr(8, 32'hDEAD); IRD = 32'h3509_0000;
    @(negedge Clk); chk("wthru_rs", RS_D_OUT, 32'hDEAD);
    tick(); chk("wthru_RSE", RSE, 32'hDEAD);

    wr(1, 7); IRD = 0; tick();
    wr(2, 7); tick();

    // beq $1,$2,-2
    RegWriteW = 0; PC4D = 32'h3004; IRD = 32'h1022_FFFE;
    @(negedge Clk);
    chk("beq_PCsrc", 32'(PCsrc), 32'd1);
    chk("beq_Branch", 32'(Branch), 32'd1);
    chk("beq_NPC", NPC, 32'h2FFC);
    tick();
    wr(2, 8);
    @(negedge Clk); chk("beq_ne_Branch", 32'(Branch), 32'd0);
    tick();

    // bltz on negative $1
    wr(1, 32'hFFFF_FFFF); IRD = 0; tick();
    RegWriteW = 0; IRD = 32'h0420_0004;
    @(negedge Clk);
    chk("bltz_Branch", 32'(Branch), 32'd1);
    chk("bltz_NPC", NPC, 32'h3014);
    tick();

    // j 0x0C00
    PC4D = 32'h3010; IRD = 32'h0800_0C00;
    @(negedge Clk);
    chk("j_PCsrc", 32'(PCsrc), 32'd2);
    chk("j_NPC", NPC, 32'h0000_3000);
    tick();

    // jr $3 with rs forwarded from M
    IRD = 32'h0060_0008; FwdRsD = 2; DataM = 32'h3040;
    @(negedge Clk);
    chk("jr_PCsrc", 32'(PCsrc), 32'd3);
    chk("jr_rs", RS_D_OUT, 32'h3040);
    tick();

    // addu $2,$1,$2: rt from E, then rt select 3 falls back to GRF
    FwdRsD = 0; FwdRtD = 1; DataE = 32'hCAFE; IRD = 32'h0022_1021;
    @(negedge Clk); chk("fwdE_rt", RT_D_OUT, 32'hCAFE);
    tick(); chk("fwdE_RTE", RTE, 32'hCAFE);
    FwdRtD = 3;
    @(negedge Clk); chk("fwd3_rt", RT_D_OUT, 32'h8);
    tick(); FwdRtD = 0;

    // stall bubble then release: lw $4,16($1)
    IRD = 32'h8C24_0010; PC4D = 32'h3020; StallD = 1;
    tick();
    chk("stall_IRE", IRE, 32'h0);
    chk("stall_PC4E", PC4E, 32'h0);
    StallD = 0;
    tick();
    chk("go_IRE", IRE, 32'h8C24_0010);
    chk("go_PC4E", PC4E, 32'h3020);

    // extender
    IRD = 32'h3401_8000; tick(); chk("ext_ori", EXTE, 32'h0000_8000);
    IRD = 32'h2401_8000; tick(); chk("ext_addiu", EXTE, 32'hFFFF_8000);
    IRD = 32'h3C01_8000; tick(); chk("ext_lui", EXTE, 32'h8000_0000);

    // reset with stall and valid instruction: bubble, GRF cleared
    Reset = 1; StallD = 1; IRD = 32'h8C24_0010;
    tick();
    chk("rst2_IRE", IRE, 32'h0);
    Reset = 0; StallD = 0; IRD = 32'h34A6_0000;
    @(negedge Clk); chk("rst2_rs5", RS_D_OUT, 32'h0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
